// File: rtl/poly_square_pkg.sv
// Shared definitions for the multi-channel square/pulse generator.
// Holds the channel-count ceiling, the default counter width, the
// channel-settings record and the period value that silences a channel.
package poly_square_pkg;

  // Largest channel count the generator is meant to be built with.
  localparam int NCH_MAX = 16;

  // Default period/high counter width; 24 bits covers more than one second at 12 MHz.
  localparam int CNT_W_DEF = 24;

  // A programmed period of zero keeps the channel silent.
  localparam int SILENT_PERIOD = 0;

  // One channel's settings at the default counter width.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
  } chan_cfg_t;

  // True when a period value means "channel produces no output".
  function automatic logic is_silent(input logic [CNT_W_DEF-1:0] period);
    return period == CNT_W_DEF'(SILENT_PERIOD);
  endfunction

endpackage

// File: rtl/poly_square_chan.sv
// One channel of the square/pulse generator.
// Keeps an active period/high pair that drives the counter and a shadow
// pair that the writer fills; the shadow only moves into the active pair
// at a period boundary (or immediately while the channel is idle), so a
// note change never produces a truncated or glitchy pulse.
// Outputs wave/wrap describe the phase the counter holds after each edge.
module poly_square_chan
  import poly_square_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             wave_o,
  output logic             wrap_o,
  output logic             pend_o
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam logic [CNT_W-1:0] SILENT = CNT_W'(SILENT_PERIOD);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             active_q, active_d;
  cfg_t             shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             running_q, running_d;
  logic             wave_q, wave_d;
  logic             wrap_q, wrap_d;

  logic             advance;
  logic             lastCycle;
  logic             restart;

  // Next-state: counter stepping, boundary apply of the shadow, shadow load and output decode.
  // "advance" is true only once the channel already showed phase cnt_q last cycle,
  // so a freshly enabled or freshly programmed channel starts its first period at phase 0.
  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;

    advance   = en_i && running_q && (active_q.period != SILENT);
    lastCycle = advance && (cnt_q == active_q.period - ONE);
    restart   = !advance || sync_i || lastCycle;

    if (restart) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // The old shadow is applied first so a write landing on the same edge
    // stays pending for the following boundary.
    if (pend_q && restart) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end

    if (wr_i) begin
      shadow_d.period = wr_period_i;
      shadow_d.high   = wr_high_i;
      pend_d          = 1'b1;
    end

    running_d = en_i && (active_d.period != SILENT);
    wave_d    = running_d && (cnt_d < active_d.high);
    wrap_d    = running_d && !(sync_i && advance) && (cnt_d == active_d.period - ONE);
  end

  // Channel state registers, cleared asynchronously so all settings are lost on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      running_q <= 1'b0;
      wave_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      running_q <= running_d;
      wave_q    <= wave_d;
      wrap_q    <= wrap_d;
    end
  end

  assign wave_o = wave_q;
  assign wrap_o = wrap_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/poly_square_gen.sv
// Multi-channel programmable square/pulse generator (top level).
// Decodes setting writes to one channel, fans the sync pulse out to all
// channels and, when POLY_SQUARE_MIX_EN is defined, adds a registered
// count of channels whose wave is currently high (port mix).
// Without POLY_SQUARE_MIX_EN there is no mix port and no counting logic.
module poly_square_gen
  import poly_square_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           en,
  input  logic                     sync,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [CNT_W-1:0]         wr_period,
  input  logic [CNT_W-1:0]         wr_high,
  output logic [NCH-1:0]           wave,
  output logic [NCH-1:0]           wrap,
  output logic [NCH-1:0]           pending
`ifdef POLY_SQUARE_MIX_EN
  ,
  output logic [$clog2(NCH+1)-1:0] mix
`endif
);

  logic [NCH-1:0] wrSel;

  // Write decode: only an index that names an existing channel selects it,
  // so out-of-range indices fall through as ignored writes.
  always_comb begin
    wrSel = '0;
    for (int i = 0; i < NCH; i++) begin
      wrSel[i] = wr_en && (wr_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    poly_square_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en[i]),
      .sync_i     (sync),
      .wr_i       (wrSel[i]),
      .wr_period_i(wr_period),
      .wr_high_i  (wr_high),
      .wave_o     (wave[i]),
      .wrap_o     (wrap[i]),
      .pend_o     (pending[i])
    );
  end

`ifdef POLY_SQUARE_MIX_EN
  localparam int MIX_W = $clog2(NCH + 1);

  logic [MIX_W-1:0] mix_q, mix_d;

  // Count the channels currently high; the result appears one cycle after wave.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NCH; i++) begin
      mix_d = mix_d + MIX_W'(wave[i]);
    end
  end

  // Mix count register, cleared with the rest of the generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix = mix_q;
`endif

endmodule

// File: tb/tb_poly_square_gen.sv
// Scoreboard bench for poly_square_gen built with three channels.
// The stimulus process pushes hand-derived per-cycle expectations; a
// monitor pops and compares them on the falling edge.
module tb_poly_square_gen;

  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic             sync = 1'b0;
  logic             wr_en = 1'b0;
  logic [CH_W-1:0]  wr_ch = '0;
  logic [CNT_W-1:0] wr_period = '0;
  logic [CNT_W-1:0] wr_high = '0;
  logic [NCH-1:0]   wave;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   pending;
  logic [1:0]       mix;

  typedef struct {
    logic [2:0] wave;
    logic [2:0] wrap;
    logic [2:0] pend;
    logic [1:0] mix;
    string      name;
  } exp_t;

  exp_t       expQ[$];
  logic [2:0] prevWave = 3'b000;
  int         total = 0;
  int         bad = 0;

  poly_square_gen #(
    .NCH  (NCH),
    .CNT_W(CNT_W),
    .CH_W (CH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_period(wr_period),
    .wr_high  (wr_high),
    .wave     (wave),
    .wrap     (wrap),
    .pending  (pending)
`ifdef POLY_SQUARE_MIX_EN
    ,
    .mix      (mix)
`endif
  );

`ifndef POLY_SQUARE_MIX_EN
  assign mix = 2'b00;
`endif

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs, then record what the outputs must be after the edge.
  task automatic applyStimulus(input logic [2:0] enV, input logic syncV, input logic wrV,
                               input logic [1:0] chV, input logic [7:0] perV, input logic [7:0] highV,
                               input logic [2:0] eWave, input logic [2:0] eWrap, input logic [2:0] ePend,
                               input string name);
    exp_t e;
    en        = enV;
    sync      = syncV;
    wr_en     = wrV;
    wr_ch     = chV;
    wr_period = perV;
    wr_high   = highV;
    @(posedge clk);
    e.wave = eWave;
    e.wrap = eWrap;
    e.pend = ePend;
    e.mix  = 2'($countones(prevWave));
    e.name = name;
    expQ.push_back(e);
    prevWave = eWave;
    #1;
  endtask

  task automatic idle(input logic [2:0] enV, input logic [2:0] eWave, input logic [2:0] eWrap,
                      input logic [2:0] ePend, input string name);
    applyStimulus(enV, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, eWave, eWrap, ePend, name);
  endtask

  task automatic resetCycle(input string name);
    exp_t e;
    rst = 1'b1;
    en = '0; sync = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    e.wave = 3'b000; e.wrap = 3'b000; e.pend = 3'b000; e.mix = 2'd0; e.name = name;
    expQ.push_back(e);
    prevWave = 3'b000;
    #1;
  endtask

  // Monitor: compare every recorded expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, "_wave"}, int'(wave), int'(e.wave));
        checkOutput({e.name, "_wrap"}, int'(wrap), int'(e.wrap));
        checkOutput({e.name, "_pend"}, int'(pending), int'(e.pend));
`ifdef POLY_SQUARE_MIX_EN
        checkOutput({e.name, "_mix"}, int'(mix), int'(e.mix));
`endif
      end
    end
  end

  initial begin
    resetCycle("reset0");
    resetCycle("reset1");
    rst = 1'b0;

    // Program ch0 per=4 high=2 from idle: pattern 1100, wrap every 4th cycle.
    applyStimulus(3'b001, 0, 1, 2'd0, 8'd4, 8'd2, 3'b000, 3'b000, 3'b001, "t1_wr");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t1_apply");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t1_c1");
    idle(3'b001, 3'b000, 3'b000, 3'b000, "t1_c2");
    idle(3'b001, 3'b000, 3'b001, 3'b000, "t1_c3");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t1_c0b");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t1_c1b");
    idle(3'b001, 3'b000, 3'b000, 3'b000, "t1_c2b");
    idle(3'b001, 3'b000, 3'b001, 3'b000, "t1_c3b");

    // Rewrite mid-period to per=6 high=3: old period finishes, then 111000.
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t2_c0");
    applyStimulus(3'b001, 0, 1, 2'd0, 8'd6, 8'd3, 3'b001, 3'b000, 3'b001, "t2_wr");
    idle(3'b001, 3'b000, 3'b000, 3'b001, "t2_c2");
    idle(3'b001, 3'b000, 3'b001, 3'b001, "t2_c3");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t2_n0");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t2_n1");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t2_n2");
    idle(3'b001, 3'b000, 3'b000, 3'b000, "t2_n3");
    idle(3'b001, 3'b000, 3'b000, 3'b000, "t2_n4");
    idle(3'b001, 3'b000, 3'b001, 3'b000, "t2_n5");
    idle(3'b001, 3'b001, 3'b000, 3'b000, "t2_n0b");
    idle(3'b000, 3'b000, 3'b000, 3'b000, "en_fall");

    // ch1: high=0 constant low, high=9 constant high, then period 0 silent.
    applyStimulus(3'b010, 0, 1, 2'd1, 8'd4, 8'd0, 3'b000, 3'b000, 3'b010, "t3_wr_h0");
    idle(3'b010, 3'b000, 3'b000, 3'b000, "t3_h0_c0");
    idle(3'b010, 3'b000, 3'b000, 3'b000, "t3_h0_c1");
    idle(3'b010, 3'b000, 3'b000, 3'b000, "t3_h0_c2");
    idle(3'b010, 3'b000, 3'b010, 3'b000, "t3_h0_c3");
    idle(3'b010, 3'b000, 3'b000, 3'b000, "t3_h0_c0b");
    applyStimulus(3'b010, 0, 1, 2'd1, 8'd4, 8'd9, 3'b000, 3'b000, 3'b010, "t3_wr_h9");
    idle(3'b010, 3'b000, 3'b000, 3'b010, "t3_h0_c2b");
    idle(3'b010, 3'b000, 3'b010, 3'b010, "t3_h0_c3b");
    idle(3'b010, 3'b010, 3'b000, 3'b000, "t3_h9_c0");
    idle(3'b010, 3'b010, 3'b000, 3'b000, "t3_h9_c1");
    idle(3'b010, 3'b010, 3'b000, 3'b000, "t3_h9_c2");
    idle(3'b010, 3'b010, 3'b010, 3'b000, "t3_h9_c3");
    idle(3'b010, 3'b010, 3'b000, 3'b000, "t3_h9_c0b");
    applyStimulus(3'b010, 0, 1, 2'd1, 8'd0, 8'd9, 3'b010, 3'b000, 3'b010, "t3_wr_p0");
    idle(3'b010, 3'b010, 3'b000, 3'b010, "t3_h9_c2b");
    idle(3'b010, 3'b010, 3'b010, 3'b010, "t3_h9_c3b");
    for (int i = 0; i < 5; i++) idle(3'b010, 3'b000, 3'b000, 3'b000, "t3_silent");

    // ch0 per=6 high=3 and ch1 per=4 high=2; sync realigns both without a wrap.
    applyStimulus(3'b000, 0, 1, 2'd1, 8'd4, 8'd2, 3'b000, 3'b000, 3'b010, "t4_wr");
    idle(3'b000, 3'b000, 3'b000, 3'b000, "t4_apply_idle");
    idle(3'b011, 3'b011, 3'b000, 3'b000, "t4_start");
    idle(3'b011, 3'b011, 3'b000, 3'b000, "t4_c1");
    idle(3'b011, 3'b001, 3'b000, 3'b000, "t4_c2");
    idle(3'b011, 3'b000, 3'b010, 3'b000, "t4_c3");
    idle(3'b011, 3'b010, 3'b000, 3'b000, "t4_c4");
    applyStimulus(3'b011, 1, 0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b000, 3'b000, "t4_sync");
    idle(3'b011, 3'b011, 3'b000, 3'b000, "t4_s1");
    idle(3'b011, 3'b001, 3'b000, 3'b000, "t4_s2");
    idle(3'b011, 3'b000, 3'b010, 3'b000, "t4_s3");

    // Write to channel index 3 does not exist in a 3-channel build.
    applyStimulus(3'b111, 0, 1, 2'd3, 8'd2, 8'd1, 3'b010, 3'b000, 3'b000, "t6_wr_oob");
    idle(3'b111, 3'b010, 3'b001, 3'b000, "t6_after1");
    idle(3'b111, 3'b001, 3'b000, 3'b000, "t6_after2");

    // Pending write, then asynchronous reset in the middle of a cycle.
    applyStimulus(3'b111, 0, 1, 2'd0, 8'd2, 8'd1, 3'b001, 3'b010, 3'b001, "t5_wr");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_wave", int'(wave), 0);
    checkOutput("rst_async_wrap", int'(wrap), 0);
    checkOutput("rst_async_pend", int'(pending), 0);
`ifdef POLY_SQUARE_MIX_EN
    checkOutput("rst_async_mix", int'(mix), 0);
`endif
    resetCycle("t5_rst0");
    resetCycle("t5_rst1");
    rst = 1'b0;
    idle(3'b111, 3'b000, 3'b000, 3'b000, "t5_lost0");
    idle(3'b111, 3'b000, 3'b000, 3'b000, "t5_lost1");
    idle(3'b111, 3'b000, 3'b000, 3'b000, "t5_lost2");

    // Reprogram all three channels to constant high; per=1 wraps every cycle.
    applyStimulus(3'b111, 0, 1, 2'd0, 8'd2, 8'd2, 3'b000, 3'b000, 3'b001, "t7_wr0");
    applyStimulus(3'b111, 0, 1, 2'd1, 8'd3, 8'd3, 3'b001, 3'b000, 3'b010, "t7_wr1");
    applyStimulus(3'b111, 0, 1, 2'd2, 8'd1, 8'd1, 3'b011, 3'b001, 3'b100, "t7_wr2");
    idle(3'b111, 3'b111, 3'b100, 3'b000, "t7_all0");
    idle(3'b111, 3'b111, 3'b111, 3'b000, "t7_all1");
    idle(3'b111, 3'b111, 3'b100, 3'b000, "t7_all2");
    idle(3'b111, 3'b111, 3'b101, 3'b000, "t7_all3");
    idle(3'b000, 3'b000, 3'b000, 3'b000, "t7_off");

    for (int k = 0; k < 8; k++) begin
      if (expQ.size() != 0) @(negedge clk);
    end
    #1;
    checkOutput("queue_drain", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
